// File: rtl/row_window_builder_if.sv
// Row/window handshake bundle between the upstream row shift register,
// the window builder and the convolution datapath.
interface row_window_builder_if #(
  parameter int ROW_SHIFT   = 3,
  parameter int WINDOW_ROWS = 3
);
  logic                                 row_shift_rdy;
  logic [ROW_SHIFT*8-1:0]               p_shift_out;
  logic                                 shift_row_up;
  logic                                 window_ready;
  logic                                 window_valid;
  logic [WINDOW_ROWS*ROW_SHIFT*8-1:0]   window_out;
  logic                                 frame_done;
  logic [15:0]                          row_count;

  // Window builder side: consumes rows, produces windows.
  modport master (
    input  row_shift_rdy,
    input  p_shift_out,
    input  window_ready,
    output shift_row_up,
    output window_valid,
    output window_out,
    output frame_done,
    output row_count
  );

  // Environment side: supplies rows and accepts windows.
  modport slave (
    output row_shift_rdy,
    output p_shift_out,
    output window_ready,
    input  shift_row_up,
    input  window_valid,
    input  window_out,
    input  frame_done,
    input  row_count
  );
endinterface

// File: rtl/row_window_builder.sv
// Stacks rows popped from the upstream row shift register into a vertical
// sliding window (stride 1) and hands each complete window downstream on a
// valid/ready handshake. Windows never straddle a frame boundary.
module row_window_builder #(
  parameter int ROW_SHIFT      = 3,
  parameter int WINDOW_ROWS    = 3,
  parameter int ROWS_PER_FRAME = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  row_window_builder_if.master   bus
);

  localparam int ROW_W  = ROW_SHIFT * 8;
  localparam int WIN_W  = WINDOW_ROWS * ROW_W;
  localparam int FILL_W = $clog2(WINDOW_ROWS + 1);

  localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(WINDOW_ROWS);
  localparam logic [FILL_W-1:0] FILL_ONE   = FILL_W'(1);
  localparam logic [15:0]       FRAME_LAST = 16'(ROWS_PER_FRAME);

  localparam logic [0:0] ST_LOAD = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  logic [0:0]        state;
  logic [ROW_W-1:0]  rows [WINDOW_ROWS];
  logic [FILL_W-1:0] fill_cnt;
  logic [FILL_W-1:0] fill_next;
  logic [15:0]       row_cnt;
  logic              pop_q;
  logic              frame_done_q;
  logic              pop;
  logic              accept;
  logic              frame_end;
  logic [WIN_W-1:0]  window_flat;

  // Pop only while loading, never on back-to-back cycles (the upstream flags
  // need a cycle to settle), and never while reset is held.
  always_comb begin
    pop = (state == ST_LOAD) & bus.row_shift_rdy & ~pop_q & ~reset;
  end

  assign accept    = (state == ST_EMIT) & bus.window_ready;
  assign frame_end = accept & (row_cnt == FRAME_LAST);
  assign fill_next = (fill_cnt == FILL_FULL) ? fill_cnt : fill_cnt + FILL_ONE;

  // Control: fill tracking, per-frame row count, LOAD/EMIT sequencing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_LOAD;
      fill_cnt     <= '0;
      row_cnt      <= '0;
      pop_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pop_q        <= pop;
      frame_done_q <= frame_end;
      if (pop) begin
        fill_cnt <= fill_next;
        row_cnt  <= row_cnt + 16'd1;
        if (fill_next == FILL_FULL) begin
          state <= ST_EMIT;
        end
      end else if (accept) begin
        state <= ST_LOAD;
        if (frame_end) begin
          row_cnt  <= '0;
          fill_cnt <= '0;
        end
      end
    end
  end

  // Row storage: shift toward index 0 on each pop, newest row at the top.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < WINDOW_ROWS; r++) begin
        rows[r] <= '0;
      end
    end else if (pop) begin
      for (int r = 0; r < WINDOW_ROWS - 1; r++) begin
        rows[r] <= rows[r + 1];
      end
      rows[WINDOW_ROWS-1] <= bus.p_shift_out;
    end
  end

  // Flatten the row registers, oldest row in the least significant slot.
  always_comb begin
    window_flat = '0;
    for (int r = 0; r < WINDOW_ROWS; r++) begin
      window_flat[r*ROW_W +: ROW_W] = rows[r];
    end
  end

  assign bus.shift_row_up = pop;
  assign bus.window_valid = (state == ST_EMIT);
  assign bus.window_out   = window_flat;
  assign bus.frame_done   = frame_done_q;
  assign bus.row_count    = row_cnt;

endmodule

// File: tb/tb_row_window_builder.sv
// Testbench for row_window_builder: directed frame/handshake/reset scenarios
// followed by randomized row availability, backpressure and resets, all
// checked every cycle against a queue-based behavioural model.
module tb_row_window_builder;

  localparam int ROW_SHIFT      = 3;
  localparam int WINDOW_ROWS    = 3;
  localparam int ROWS_PER_FRAME = 4;
  localparam int ROW_W          = ROW_SHIFT * 8;
  localparam int WIN_W          = WINDOW_ROWS * ROW_W;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;
  int row_idx      = 0;
  bit model_on     = 1'b0;

  row_window_builder_if #(.ROW_SHIFT(ROW_SHIFT), .WINDOW_ROWS(WINDOW_ROWS)) bus ();

  row_window_builder #(
    .ROW_SHIFT      (ROW_SHIFT),
    .WINDOW_ROWS    (WINDOW_ROWS),
    .ROWS_PER_FRAME (ROWS_PER_FRAME)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Upstream row n carries pixels {3n+2, 3n+1, 3n}.
  function automatic logic [ROW_W-1:0] rowData(input int n);
    rowData = {8'(3*n + 2), 8'(3*n + 1), 8'(3*n)};
  endfunction

  assign bus.p_shift_out = rowData(row_idx);

  // Upstream model: the next row shows up in the cycle after each pop.
  always @(posedge clock) begin
    if (bus.shift_row_up) row_idx <= row_idx + 1;
  end

  // ---------------- behavioural model ----------------
  logic [ROW_W-1:0] m_hist[$];
  int m_next_row   = 0;
  int m_frame_rows = 0;
  int m_fill       = 0;
  bit m_emit       = 1'b0;
  bit m_last_pop   = 1'b0;
  bit m_done       = 1'b0;

  function automatic bit modelPop();
    modelPop = !reset && !m_emit && bus.row_shift_rdy && !m_last_pop;
  endfunction

  function automatic logic [WIN_W-1:0] modelWindow();
    logic [WIN_W-1:0] w;
    w = '0;
    for (int r = 0; r < WINDOW_ROWS; r++) w[r*ROW_W +: ROW_W] = m_hist[r];
    modelWindow = w;
  endfunction

  task automatic modelReset();
    m_hist = {};
    for (int r = 0; r < WINDOW_ROWS; r++) m_hist.push_back('0);
    m_frame_rows = 0;
    m_fill       = 0;
    m_emit       = 1'b0;
    m_last_pop   = 1'b0;
    m_done       = 1'b0;
  endtask

  // Advance the model on each clock edge using the inputs seen before it.
  always @(posedge clock) begin : model_step
    bit pop_now;
    bit accept_now;
    pop_now    = modelPop();
    accept_now = m_emit && bus.window_ready;
    if (reset) begin
      modelReset();
    end else begin
      m_done = accept_now && (m_frame_rows == ROWS_PER_FRAME);
      if (pop_now) begin
        m_hist.push_back(rowData(m_next_row));
        void'(m_hist.pop_front());
        m_next_row++;
        m_frame_rows++;
        if (m_fill < WINDOW_ROWS) m_fill++;
        if (m_fill == WINDOW_ROWS) m_emit = 1'b1;
      end
      if (accept_now) begin
        m_emit = 1'b0;
        if (m_done) begin
          m_frame_rows = 0;
          m_fill       = 0;
        end
      end
      m_last_pop = pop_now;
    end
    model_on = 1'b1;
  end

  task automatic checkOutput(input string name, input logic [WIN_W-1:0] actual,
                             input logic [WIN_W-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    if (model_on) begin
      checkOutput("model shift_row_up", WIN_W'(bus.shift_row_up), WIN_W'(modelPop()));
      checkOutput("model window_valid", WIN_W'(bus.window_valid), WIN_W'(m_emit));
      checkOutput("model frame_done",   WIN_W'(bus.frame_done),   WIN_W'(m_done));
      checkOutput("model row_count",    WIN_W'(bus.row_count),    WIN_W'(m_frame_rows));
      if (m_emit) checkOutput("model window_out", bus.window_out, modelWindow());
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic applyStimulus(input bit rdy, input bit win_rdy, input bit rst);
    @(posedge clock);
    #1;
    bus.row_shift_rdy = rdy;
    bus.window_ready  = win_rdy;
    reset             = rst;
  endtask

  task automatic waitValid(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (bus.window_valid) break;
    end
    checkOutput(name, WIN_W'(bus.window_valid), WIN_W'(1));
  endtask

  task automatic waitRowCount(input string name, input int value, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clock);
      if (bus.row_count == 16'(value)) break;
    end
    checkOutput(name, WIN_W'(bus.row_count), WIN_W'(value));
  endtask

  initial begin
    logic [WIN_W-1:0] held;
    bus.row_shift_rdy = 1'b1;
    bus.window_ready  = 1'b1;
    reset             = 1'b1;

    // Reset held with rows available: nothing pops, everything reads zero.
    repeat (2) @(posedge clock);
    @(negedge clock);
    checkOutput("reset shift_row_up", WIN_W'(bus.shift_row_up), 0);
    checkOutput("reset window_valid", WIN_W'(bus.window_valid), 0);
    checkOutput("reset frame_done",   WIN_W'(bus.frame_done),   0);
    checkOutput("reset row_count",    WIN_W'(bus.row_count),    0);
    checkOutput("reset window_out",   bus.window_out,           0);

    // First window of frame 0: rows 0..2.
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitValid("win0 valid", 20);
    checkOutput("win0 data", bus.window_out, 72'h080706050403020100);
    checkOutput("win0 row_count", WIN_W'(bus.row_count), 3);

    // Second window (rows 1..3) closes the frame.
    @(negedge clock);
    checkOutput("win0 accepted", WIN_W'(bus.window_valid), 0);
    waitValid("win1 valid", 20);
    checkOutput("win1 data", bus.window_out, 72'h0b0a09080706050403);
    checkOutput("win1 row_count", WIN_W'(bus.row_count), 4);
    @(negedge clock);
    checkOutput("frame0 done pulse", WIN_W'(bus.frame_done), 1);
    checkOutput("frame0 row_count cleared", WIN_W'(bus.row_count), 0);
    @(negedge clock);
    checkOutput("frame0 done one cycle", WIN_W'(bus.frame_done), 0);

    // Backpressure on frame 1's first window (rows 4..6).
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitValid("win2 valid", 20);
    held = bus.window_out;
    checkOutput("win2 data", held, 72'h14131211100f0e0d0c);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("hold valid", WIN_W'(bus.window_valid), 1);
      checkOutput("hold data", bus.window_out, held);
      checkOutput("hold no pop", WIN_W'(bus.shift_row_up), 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("release still valid", WIN_W'(bus.window_valid), 1);
    @(negedge clock);
    checkOutput("release accepted", WIN_W'(bus.window_valid), 0);
    checkOutput("release row_count", WIN_W'(bus.row_count), 3);

    // Row starvation mid-fill of frame 2.
    waitRowCount("frame2 first row", 1, 30);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkOutput("starve row_count", WIN_W'(bus.row_count), 1);
      checkOutput("starve no pop", WIN_W'(bus.shift_row_up), 0);
    end
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitValid("win4 valid", 20);
    checkOutput("win4 data", bus.window_out, 72'h201f1e1d1c1b1a1918);

    // Reset after two pops of frame 3: rows 12,13 are lost.
    waitRowCount("frame3 two rows", 2, 30);
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clock);
    checkOutput("reset cycle no pop", WIN_W'(bus.shift_row_up), 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(negedge clock);
    checkOutput("post reset row_count", WIN_W'(bus.row_count), 0);
    checkOutput("post reset valid", WIN_W'(bus.window_valid), 0);
    waitValid("win6 valid", 20);
    checkOutput("win6 data", bus.window_out, 72'h3231302f2e2d2c2b2a);

    // Randomized rows, backpressure and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 199) == 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/row_window_builder.md
# row_window_builder

Consumes parallel pixel rows from the upstream row shift register (`row_sr`) and stacks them into a vertical sliding window of `WINDOW_ROWS` rows × `ROW_SHIFT` pixels for the convolution datapath.
- Pops one row at a time with the show-ahead `shift_row_up` request.
- Presents each complete window on a valid/ready handshake.
- Tracks frame boundaries so a window never spans two frames.

## Interface
- `ROW_SHIFT`, 3: pixels per row; must match the upstream `ROW_SHIFT`.
- `WINDOW_ROWS`, 3: rows per window (≥2).
- `ROWS_PER_FRAME`, 8: rows per frame (≥ `WINDOW_ROWS`, < 65536).

Ports:
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `row_shift_rdy`  in  1  upstream has a full row on `p_shift_out`.
- `p_shift_out`  in  `ROW_SHIFT*8`  upstream row; pixel 0 in [7:0].
- `shift_row_up`  out  1  one-cycle pop request; consumes the presented row.
- `window_ready`  in  1  downstream accepts the window.
- `window_valid`  out  1  `window_out` holds a complete window.
- `window_out`  out  `WINDOW_ROWS*ROW_SHIFT*8`  row r (r=0 oldest) at bits [(r+1)*ROW_SHIFT*8-1 : r*ROW_SHIFT*8].
- `frame_done`  out  1  one-cycle pulse after the last window of a frame is accepted.
- `row_count`  out  16  rows popped in the current frame.

## Operation
- Internal state:
  - `WINDOW_ROWS` row registers.
  - `fill_cnt`, saturating at `WINDOW_ROWS`.
  - `row_count`.
  - `pop_q`, the registered `shift_row_up`.
  - Two-state FSM: LOAD and EMIT.
- **LOAD:**
  - `shift_row_up = row_shift_rdy & ~pop_q` (combinational). A pop is never issued in two consecutive cycles, which gives the upstream flags one cycle to settle after each pop.
  - At a pop edge:
    - Row registers shift toward index 0 (oldest discarded).
    - Row `WINDOW_ROWS-1` ← `p_shift_out`.
    - `fill_cnt`++ (saturating) and `row_count`++.
  - If the post-pop `fill_cnt` == `WINDOW_ROWS`, go to EMIT; otherwise stay in LOAD.
- **EMIT:**
  - `window_valid`=1 and `shift_row_up`=0.
  - Row registers are frozen, so `window_out` is stable while valid.
  - On `window_valid & window_ready`:
    - If `row_count` == `ROWS_PER_FRAME`: `row_count`←0, `fill_cnt`←0, `frame_done`←1 for the next cycle only.
    - Go to LOAD.
  - `fill_cnt` stays at `WINDOW_ROWS` within a frame, so each later row yields a new window (stride 1).
  - Windows per frame = `ROWS_PER_FRAME - WINDOW_ROWS + 1`.
- **Reset:**
  - State = LOAD; `fill_cnt`, `row_count`, `pop_q` and all row registers = 0.
  - `window_valid`=0, `frame_done`=0, `shift_row_up`=0 (forced 0 while `reset`=1).
- **Reset mid-operation:** any partial or pending window is dropped without being emitted. No pop is issued during the reset cycle. A full `WINDOW_ROWS` refill is needed after reset.
- `row_shift_rdy` low in LOAD: the block waits with no pop and no state change.
- `row_shift_rdy` in EMIT is ignored.
- `window_ready` in LOAD is ignored.

## Timing
- Pop edge E completing a window → `window_valid`=1 in the cycle after E.
- `window_valid` stays high until the accept edge A.
- The earliest next pop is in the cycle after A.
- Throughput, with `row_shift_rdy` and `window_ready` held high:
  - 2 cycles per row during fill.
  - Steady state: one window per 2 cycles (pop cycle + EMIT cycle).
- `frame_done` is high exactly in the cycle after the final accept of a frame.
- `row_count` reads 0 in that same cycle.
- `row_count` updates on the pop edge and is visible in the following cycle.

## Test plan
Bench setup: `ROW_SHIFT`=3, `WINDOW_ROWS`=3, `ROWS_PER_FRAME`=4. The upstream model presents row n = {3n+2, 3n+1, 3n} (MSB→LSB) and advances one cycle after each pop.

1. Reset with `row_shift_rdy`=1 → `shift_row_up`=0; `window_valid`, `frame_done`, `row_count` and `window_out` all 0.
2. `row_shift_rdy`=1, `window_ready`=1 after reset → pops in alternating cycles (3 pops) → `window_valid`=1 one cycle after the third pop, with byte k of `window_out` = k for k=0..8, and `row_count`=3.
3. Continue from 2 → fourth pop gives a window with bytes 3..11 → after it is accepted, `frame_done` pulses for one cycle and `row_count`=0. The next frame needs 3 pops before the next `window_valid`.
4. Hold `window_ready`=0 for 5 cycles while `window_valid`=1 → `window_valid` stays 1, `window_out` is unchanged and `shift_row_up` stays 0. Raising `window_ready` → accept on that edge and `window_valid`=0 in the next cycle.
5. Drop `row_shift_rdy` for 4 cycles mid-fill → no pops and `fill_cnt`/`row_count` hold. Restore it → pops resume and the window data is contiguous, with no skipped or duplicated row.
6. Pulse `reset` after 2 pops → `row_count`=0 and no `window_valid`. The next 3 pops produce a window containing only post-reset rows.
